spi_psram_loader: RTL and testbench

SPI_PSRAM_LOADER -- requirements
Module: spi_psram_loader

---
 rtl/spi_psram_pkg.sv | 10 +
 rtl/spi_rx_sync.sv | 36 +++
 rtl/spi_psram_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_psram_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_psram_pkg.sv
// Shared command codes and state encodings for the SPI-to-PSRAM loader.
package spi_psram_pkg;

  localparam logic [7:0] CMD_WR = 8'hA0;
  localparam logic [7:0] CMD_RD = 8'hB0;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, SKIP} main_state_e;
  typedef enum logic [1:0] {P_IDLE, P_WR, P_RD, P_REC} psr_state_e;

endpackage

// File: rtl/spi_rx_sync.sv
// Two-flop synchronisers for the MCU SPI pins plus SCK edge detection in the CLK domain.
module spi_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ssn_i,
  input  logic sck_i,
  input  logic mosi_i,
  output logic ssn_o,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);

  logic [1:0] ssn_q;
  logic [1:0] mosi_q;
  logic [2:0] sck_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ssn_q  <= 2'b11;
      mosi_q <= 2'b00;
      sck_q  <= 3'b000;
    end else begin
      ssn_q  <= {ssn_q[0], ssn_i};
      mosi_q <= {mosi_q[0], mosi_i};
      sck_q  <= {sck_q[1:0], sck_i};
    end
  end

  // MOSI and SCK share the same sync depth, so mosi_o is aligned with sck_rise_o.
  assign ssn_o      = ssn_q[1];
  assign mosi_o     = mosi_q[1];
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];

endmodule

// File: rtl/spi_psram_loader.sv
// SPI slave (mode 0) that writes and reads byte-wide data in a 16-bit async PSRAM.
module spi_psram_loader
  import spi_psram_pkg::*;
#(
  parameter int PSR_WR_CYC = 4,
  parameter int PSR_RD_CYC = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SPI_SSn,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic [21:0] PSR_A,
  input  logic [15:0] PSR_DI,
  output logic [15:0] PSR_DO,
  output logic        PSR_DOE,
  output logic        PSR_CEn,
  output logic        PSR_OEn,
  output logic        PSR_WEn,
  output logic        PSR_UBn,
  output logic        PSR_LBn,
  output logic        BUSY
);

  logic ssn_s, mosi_s, sck_rise, sck_fall;

  spi_rx_sync u_sync (
    .clk_i      (CLK),
    .rst_i      (RST),
    .ssn_i      (SPI_SSn),
    .sck_i      (SPI_SCK),
    .mosi_i     (SPI_MOSI),
    .ssn_o      (ssn_s),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall)
  );

  main_state_e state_q, state_d;
  psr_state_e  pstate_q, pstate_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [6:0]  rx_sr_q, rx_sr_d;
  logic [6:0]  tx_sr_q, tx_sr_d;
  logic [22:0] addr_q, addr_d;
  logic        is_wr_q, is_wr_d;
  logic        miso_q, miso_d;
  logic        tx_need_q, tx_need_d;
  logic [7:0]  rx_byte;
  logic        new_req, new_wr, tx_load;

  logic        req_pend_q, req_pend_d, req_wr_q, req_wr_d;
  logic [22:0] req_addr_q, req_addr_d;
  logic [7:0]  req_data_q, req_data_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic [21:0] pa_q, pa_d;
  logic        plsb_q, plsb_d;
  logic [15:0] pdo_q, pdo_d;
  logic [7:0]  rd_buf_q, rd_buf_d;
  logic        rd_vld_q, rd_vld_d;

  // Frame decode and serial shifters
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    addr_d     = addr_q;
    is_wr_d    = is_wr_q;
    miso_d     = miso_q;
    tx_need_d  = tx_need_q;
    rx_byte    = {rx_sr_q, mosi_s};
    new_req    = 1'b0;
    new_wr     = 1'b0;
    tx_load    = 1'b0;
    if (state_q == IDLE || ssn_s) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      miso_d     = 1'b0;
      tx_need_d  = 1'b0;
      state_d    = ssn_s ? IDLE : CMD;
    end else begin
      if (sck_rise) begin
        rx_sr_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              is_wr_d = (rx_byte == CMD_WR);
              state_d = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ADDR : SKIP;
            end
            ADDR: begin
              addr_d     = {addr_q[14:0], rx_byte};
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd2) state_d = is_wr_q ? WDATA : DUMMY;
            end
            DUMMY: begin
              new_req = 1'b1;
              addr_d  = addr_q + 23'd1;
              state_d = RDATA;
            end
            WDATA: begin
              new_req = 1'b1;
              new_wr  = 1'b1;
              addr_d  = addr_q + 23'd1;
            end
            default: ;
          endcase
        end
      end
      if (state_q == RDATA) begin
        if (sck_fall) begin
          if (bit_cnt_q == 3'd0) tx_need_d = 1'b1;
          else begin
            miso_d  = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
          end
        end
        // Loading the next byte also launches the prefetch for the one after it.
        if (tx_need_q && rd_vld_q) begin
          tx_load   = 1'b1;
          miso_d    = rd_buf_q[7];
          tx_sr_d   = rd_buf_q[6:0];
          tx_need_d = 1'b0;
          new_req   = 1'b1;
          addr_d    = addr_q + 23'd1;
        end
      end
    end
  end

  // PSRAM access sequencer; one pending request is held while a cycle is active
  always_comb begin
    pstate_d   = pstate_q;
    pcnt_d     = pcnt_q;
    pa_d       = pa_q;
    plsb_d     = plsb_q;
    pdo_d      = pdo_q;
    rd_buf_d   = rd_buf_q;
    rd_vld_d   = (state_q == RDATA) ? rd_vld_q : 1'b0;
    req_pend_d = req_pend_q;
    req_wr_d   = req_wr_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    if (tx_load) rd_vld_d = 1'b0;
    case (pstate_q)
      P_IDLE: if (req_pend_q) begin
        pstate_d   = req_wr_q ? P_WR : P_RD;
        pcnt_d     = 3'd0;
        pa_d       = req_addr_q[22:1];
        plsb_d     = req_addr_q[0];
        req_pend_d = 1'b0;
        if (req_wr_q) pdo_d = {req_data_q, req_data_q};
      end
      P_WR: begin
        pcnt_d = pcnt_q + 3'd1;
        if (pcnt_q == 3'(PSR_WR_CYC + 1)) pstate_d = P_REC;
      end
      P_RD: begin
        pcnt_d = pcnt_q + 3'd1;
        if (pcnt_q == 3'(PSR_RD_CYC - 1)) begin
          pstate_d = P_REC;
          rd_buf_d = plsb_q ? PSR_DI[7:0] : PSR_DI[15:8];
          rd_vld_d = 1'b1;
        end
      end
      default: pstate_d = P_IDLE;
    endcase
    if (new_req) begin
      req_pend_d = 1'b1;
      req_wr_d   = new_wr;
      req_addr_d = addr_q;
      req_data_d = rx_byte;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pstate_q   <= P_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      addr_q     <= '0;
      is_wr_q    <= 1'b0;
      miso_q     <= 1'b0;
      tx_need_q  <= 1'b0;
      req_pend_q <= 1'b0;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      pcnt_q     <= '0;
      pa_q       <= '0;
      plsb_q     <= 1'b0;
      pdo_q      <= '0;
      rd_buf_q   <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pstate_q   <= pstate_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      addr_q     <= addr_d;
      is_wr_q    <= is_wr_d;
      miso_q     <= miso_d;
      tx_need_q  <= tx_need_d;
      req_pend_q <= req_pend_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      pcnt_q     <= pcnt_d;
      pa_q       <= pa_d;
      plsb_q     <= plsb_d;
      pdo_q      <= pdo_d;
      rd_buf_q   <= rd_buf_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // Write: DOE leads WEn by one cycle and trails it by one; strobes decode from async-reset state.
  logic wr_act, rd_act;
  assign wr_act   = (pstate_q == P_WR) && (pcnt_q >= 3'd1) && (pcnt_q <= 3'(PSR_WR_CYC));
  assign rd_act   = (pstate_q == P_RD);
  assign PSR_CEn  = ~(wr_act | rd_act);
  assign PSR_WEn  = ~wr_act;
  assign PSR_OEn  = ~rd_act;
  assign PSR_UBn  = ~((wr_act | rd_act) & ~plsb_q);
  assign PSR_LBn  = ~((wr_act | rd_act) & plsb_q);
  assign PSR_DOE  = (pstate_q == P_WR);
  assign PSR_A    = pa_q;
  assign PSR_DO   = pdo_q;
  assign SPI_MISO = miso_q;
  assign BUSY     = ~ssn_s | (pstate_q != P_IDLE) | req_pend_q;

endmodule

// File: tb/tb_spi_psram_loader.sv
// Bench for spi_psram_loader: MCU-side SPI driver, byte-level PSRAM model and memory scoreboard.
module tb_spi_psram_loader;

  localparam int WR   = 4;
  localparam int RD   = 4;
  localparam int HALF = 8;

  logic        clk = 1'b0, rst, ssn, sck, mosi, miso;
  logic [21:0] psr_a;
  logic [15:0] psr_di = 16'h0000, psr_do;
  logic        doe, cen, oen, wen, ubn, lbn, busy;

  spi_psram_loader #(.PSR_WR_CYC(WR), .PSR_RD_CYC(RD)) dut (
    .CLK(clk), .RST(rst), .SPI_SSn(ssn), .SPI_SCK(sck), .SPI_MOSI(mosi), .SPI_MISO(miso),
    .PSR_A(psr_a), .PSR_DI(psr_di), .PSR_DO(psr_do), .PSR_DOE(doe), .PSR_CEn(cen),
    .PSR_OEn(oen), .PSR_WEn(wen), .PSR_UBn(ubn), .PSR_LBn(lbn), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [22:0] a; logic [7:0] d; } wr_t;

  int          checks = 0, errors = 0;
  logic [7:0]  pmem    [logic [22:0]];   // contents of the simulated PSRAM chip
  logic [7:0]  ref_mem [logic [22:0]];   // contents implied by the frames sent
  wr_t         exp_wr[$];
  int          pulses = 0, wlen = 0;
  logic        wen_prev = 1'b1, quiet = 1'b0;
  logic [21:0] last_wr_a = '0;
  logic [7:0]  wdat [8];
  logic [7:0]  rdat [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pm_rd(input logic [22:0] a);
    return pmem.exists(a) ? pmem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [22:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // PSRAM model and per-cycle write-cycle checks
  always @(negedge clk) begin
    if (rst) begin
      wlen = 0;
      wen_prev = 1'b1;
      exp_wr.delete();
    end else begin
      psr_di = {pm_rd({psr_a, 1'b0}), pm_rd({psr_a, 1'b1})};
      if (!wen) begin
        if (wen_prev) begin pulses++; last_wr_a = psr_a; end
        wlen++;
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          chk("wr_addr", psr_a, exp_wr[0].a[22:1]);
          chk("wr_ubn", ubn, exp_wr[0].a[0]);
          chk("wr_lbn", lbn, !exp_wr[0].a[0]);
          chk("wr_do", psr_do, {exp_wr[0].d, exp_wr[0].d});
        end
        chk("wr_cen", cen, 0);
        chk("wr_doe", doe, 1);
        if (!ubn) pmem[{psr_a, 1'b0}] = psr_do[15:8];
        if (!lbn) pmem[{psr_a, 1'b1}] = psr_do[7:0];
      end else if (!wen_prev) begin
        chk("wr_len", wlen, WR);
        chk("doe_trail", doe, 1);
        wlen = 0;
        if (exp_wr.size() != 0) void'(exp_wr.pop_front());
      end
      if (quiet) begin
        chk("quiet_cen", cen, 1);
        chk("quiet_miso", miso, 0);
      end
      wen_prev = wen;
    end
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      rx = {rx[6:0], miso};
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [22:0] a);
    logic [7:0] rx;
    ssn = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("busy_frame", busy, 1);
    spi_xfer(cmd, 8, rx);
    spi_xfer({1'b0, a[22:16]}, 8, rx);
    spi_xfer(a[15:8], 8, rx);
    spi_xfer(a[7:0], 8, rx);
  endtask

  task automatic frame_stop();
    int n = 0;
    repeat (HALF) @(negedge clk);
    ssn = 1'b1;
    repeat (4) @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("idle_reached", busy, 0);
  endtask

  task automatic do_write(input logic [22:0] a, input int n);
    logic [7:0] rx;
    send_hdr(8'hA0, a);
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back('{a: a + 23'(i), d: wdat[i]});
      ref_mem[a + 23'(i)] = wdat[i];
      spi_xfer(wdat[i], 8, rx);
    end
    frame_stop();
    for (int i = 0; i < n; i++) chk("wr_mem", pm_rd(a + 23'(i)), ref_rd(a + 23'(i)));
  endtask

  task automatic do_read(input logic [22:0] a, input int n);
    logic [7:0] rx;
    send_hdr(8'hB0, a);
    spi_xfer(8'hFF, 8, rx);
    for (int i = 0; i < n; i++) begin
      spi_xfer(8'hFF, 8, rdat[i]);
      chk("rd_byte", rdat[i], ref_rd(a + 23'(i)));
    end
    frame_stop();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_strobes"}, {cen, oen, wen, ubn, lbn, doe, miso, busy}, 8'b11111000);
    chk({tag, "_a"}, psr_a, 0);
    chk({tag, "_do"}, psr_do, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, rx_or;
    int p0, cnt;
    logic [22:0] a;
    int n;
    rst = 1'b1; ssn = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two-byte write straddling one PSRAM word
    p0 = pulses;
    wdat[0] = 8'h55; wdat[1] = 8'hAA;
    do_write(23'h000010, 2);
    chk("wt_hi", pm_rd(23'h10), 8'h55);
    chk("wt_lo", pm_rd(23'h11), 8'hAA);
    chk("wt_pulses", pulses - p0, 2);
    chk("wt_addr", last_wr_a, 22'h000008);

    // Preloaded word read back
    pmem[23'h10] = 8'h12; pmem[23'h11] = 8'h34;
    ref_mem[23'h10] = 8'h12; ref_mem[23'h11] = 8'h34;
    do_read(23'h000010, 2);
    chk("rt_b0", rdat[0], 8'h12);
    chk("rt_b1", rdat[1], 8'h34);

    // Address wrap
    wdat[0] = 8'h11; wdat[1] = 8'h22;
    do_write(23'h7FFFFF, 2);
    chk("wrap_top", pm_rd(23'h7FFFFF), 8'h11);
    chk("wrap_zero", pm_rd(23'h000000), 8'h22);
    do_read(23'h7FFFFF, 2);

    // Unknown command is ignored
    p0 = pulses; rx_or = 8'h00; quiet = 1'b1;
    ssn = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_xfer(8'h3C, 8, rx); rx_or |= rx;
    for (int i = 1; i <= 4; i++) begin spi_xfer(8'(i), 8, rx); rx_or |= rx; end
    frame_stop();
    quiet = 1'b0;
    chk("unk_miso", rx_or, 0);
    chk("unk_pulses", pulses - p0, 0);

    // Abort after four bits of the second data byte
    send_hdr(8'hA0, 23'h000100);
    exp_wr.push_back('{a: 23'h000100, d: 8'h5E});
    ref_mem[23'h000100] = 8'h5E;
    spi_xfer(8'h5E, 8, rx);
    spi_xfer(8'hC3, 4, rx);
    ssn = 1'b1;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("abort_busy_fast", cnt <= WR + 3, 1);
    chk("abort_b0", pm_rd(23'h000100), 8'h5E);
    chk("abort_b1", pm_rd(23'h000101), 8'h00);

    // Reset asserted while WEn is low
    send_hdr(8'hA0, 23'h000200);
    exp_wr.push_back('{a: 23'h000200, d: 8'h77});
    spi_xfer(8'h77, 8, rx);
    cnt = 0;
    while (wen && cnt < 100) begin @(negedge clk); cnt++; end
    chk("rstw_wen_low", wen, 0);
    #2 rst = 1'b1;
    #1 chk_reset_outs("rst_mid");
    ssn = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wdat[0] = 8'h5A; wdat[1] = 8'h5B;
    do_write(23'h000300, 2);
    do_read(23'h000300, 2);
    chk("post_rst_b0", rdat[0], 8'h5A);
    chk("post_rst_b1", rdat[1], 8'h5B);

    // Randomised write/read-back frames
    for (int k = 0; k < 6; k++) begin
      a = 23'($urandom) | 23'h000400;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
      do_write(a, n);
      do_read(a, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
